tbt_mult_host: RTL and testbench

//  Host-side driver for the 2x2 IEEE-754 single-precision matrix multiplier (tbt_mult_async).

---
 rtl/tbt_pkg.sv | 20 ++
 rtl/tbt_word_packer.sv | 52 +++++
 rtl/tbt_mult_host.sv | 133 +++++++++++++
 tb/tb_tbt_mult_host.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbt_pkg.sv
// rtl/tbt_pkg.sv - shared types and constants for the 2x2 matrix multiplier host
package tbt_pkg;

    localparam int WORD_W = 32;
    localparam int MAT_W  = 4 * WORD_W;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_LOAD,
        ST_WAIT,
        ST_ACK,
        ST_EMIT
    } state_t;

    // Element k of a row-major 2x2 matrix sits at the top of the bus for k=0.
    function automatic int slot_lsb(input int k);
        return (3 - (k % 4)) * WORD_W;
    endfunction

endpackage

// File: rtl/tbt_word_packer.sv
// rtl/tbt_word_packer.sv - 8-slot operand register packing A then B into matrix buses
module tbt_word_packer
    import tbt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic              clr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic [MAT_W-1:0]  mat_a_o,
    output logic [MAT_W-1:0]  mat_b_o,
    output logic              last_o
);

    logic [MAT_W-1:0] a_q, a_d;
    logic [MAT_W-1:0] b_q, b_d;
    logic [2:0]       idx_q, idx_d;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (wr_en_i) begin
            // idx bit 2 selects B; the low two bits pick the element slot.
            if (idx_q[2]) begin
                b_d[slot_lsb(int'(idx_q)) +: WORD_W] = wr_data_i;
            end else begin
                a_d[slot_lsb(int'(idx_q)) +: WORD_W] = wr_data_i;
            end
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            idx_q <= idx_d;
        end
    end

    assign mat_a_o = a_q;
    assign mat_b_o = b_q;
    assign last_o  = wr_en_i && (idx_q == 3'd7);

endmodule

// File: rtl/tbt_mult_host.sv
// rtl/tbt_mult_host.sv - word-stream host driving the 2x2 float matrix multiplier handshake
module tbt_mult_host
    import tbt_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mult_load,
    output logic [MAT_W-1:0]  mult_A,
    output logic [MAT_W-1:0]  mult_B,
    input  logic [MAT_W-1:0]  mult_result,
    input  logic              mult_result_ready,
    output logic              mult_result_ack,
    output logic              busy,
    output logic              timeout_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        out_idx_q, out_idx_d;
    logic [MAT_W-1:0]  result_q, result_d;
    logic              err_q, err_d;
    logic              ready_en_q;
    logic              wr_en;
    logic              clr_idx;
    logic              last_word;

    tbt_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .clr_i     (clr_idx),
        .wr_data_i (in_data),
        .mat_a_o   (mult_A),
        .mat_b_o   (mult_B),
        .last_o    (last_word)
    );

    // Keeps in_ready low in the first cycle after reset so every output reads 0 in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_idx_d = out_idx_q;
        result_d  = result_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        clr_idx   = 1'b0;
        unique case (state_q)
            ST_COLLECT: begin
                if (in_valid && in_ready) begin
                    wr_en = 1'b1;
                    err_d = 1'b0;
                    if (last_word) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mult_result_ready) begin
                    result_d = mult_result;
                    state_d  = ST_ACK;
                end else if (cnt_d == CNT_LAST) begin
                    err_d   = 1'b1;
                    clr_idx = 1'b1;
                    state_d = ST_COLLECT;
                end
            end
            ST_ACK: begin
                out_idx_d = '0;
                if (!mult_result_ready) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    out_idx_d = out_idx_q + 2'd1;
                    if (out_idx_q == 2'd3) begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            out_idx_q <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_idx_q <= out_idx_d;
            result_q  <= result_d;
            err_q     <= err_d;
        end
    end

    assign in_ready        = (state_q == ST_COLLECT) && ready_en_q;
    assign mult_load       = (state_q == ST_LOAD);
    assign mult_result_ack = (state_q == ST_ACK);
    assign out_valid       = (state_q == ST_EMIT);
    assign busy            = (state_q != ST_COLLECT);
    assign timeout_err     = err_q;
    assign out_data        = result_q[slot_lsb(int'(out_idx_q)) +: WORD_W];

endmodule

// File: tb/tb_tbt_mult_host.sv
// tb/tb_tbt_mult_host.sv - scoreboard bench for tbt_mult_host with a behavioural float multiplier
module tb_tbt_mult_host;

    localparam int TO = 16;

    typedef logic [31:0] words_t [8];
    typedef struct packed {
        logic [31:0] w;
        logic        tol;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         mult_load;
    logic [127:0] mult_A;
    logic [127:0] mult_B;
    logic [127:0] mult_result;
    logic         mult_result_ready;
    logic         mult_result_ack;
    logic         busy;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;
    int loads  = 0;

    exp_t         exp_q[$];
    logic [255:0] ab_q[$];

    tbt_mult_host #(.TIMEOUT(TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .mult_load         (mult_load),
        .mult_A            (mult_A),
        .mult_B            (mult_B),
        .mult_result       (mult_result),
        .mult_result_ready (mult_result_ready),
        .mult_result_ack   (mult_result_ack),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    // ---------------- float reference ----------------
    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = int'(d[62:52]) - 896;
        m = {2'b01, d[51:29]} + 25'(d[28] && ((|d[27:0]) || d[29]));
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hff, 23'd0};
        return {d[63], e[7:0], m[22:0]};
    endfunction

    // C[i][j] = sum_k A[i][k]*B[k][j]; words 0..3 are A row-major, 4..7 are B row-major.
    function automatic logic [127:0] ref_mul(input words_t w);
        logic [127:0] res;
        real          s;
        res = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = f2r(w[2*i]) * f2r(w[4+j]) + f2r(w[2*i+1]) * f2r(w[6+j]);
                res[127-32*(2*i+j) -: 32] = r2f(s);
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] rand_word();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    // ---------------- behavioural multiplier ----------------
    int   delay_cfg = 3;
    int   hold_cfg  = 0;
    bit   never_mode = 1'b0;
    logic late_rdy;
    logic rr;
    bit   m_pend;
    int   m_cnt;
    int   m_hold;

    assign mult_result_ready = rr | late_rdy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr          <= 1'b0;
            m_pend      <= 1'b0;
            m_cnt       <= 0;
            m_hold      <= 0;
            mult_result <= '0;
        end else begin
            if (mult_load && !never_mode) begin
                words_t ww;
                for (int k = 0; k < 4; k++) begin
                    ww[k]   = mult_A[127-32*k -: 32];
                    ww[k+4] = mult_B[127-32*k -: 32];
                end
                mult_result <= ref_mul(ww);
                m_pend      <= 1'b1;
                m_cnt       <= delay_cfg;
            end else if (m_pend) begin
                if (m_cnt == 0) begin
                    rr     <= 1'b1;
                    m_pend <= 1'b0;
                    m_hold <= hold_cfg;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (rr && mult_result_ack) begin
                if (m_hold == 0) rr <= 1'b0;
                else m_hold <= m_hold - 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not met within bound", name);
    endtask

    task automatic abort(input string name);
        fail_now(name);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "bench aborted");
    endtask

    task automatic chk_ulp(input string name, input logic [31:0] act, input logic [31:0] exp);
        logic [30:0] diff;
        checks++;
        diff = (act[30:0] > exp[30:0]) ? act[30:0] - exp[30:0] : exp[30:0] - act[30:0];
        if (act[31] !== exp[31] || diff > 31'd1) begin
            errors++;
            $display("FAIL %s: got %h expected %h (1 ulp)", name, act, exp);
        end
    endtask

    // ---------------- output back-pressure driver ----------------
    int or_mode = 0;
    int or_ph   = 0;
    always @(posedge clk) begin
        #1;
        case (or_mode)
            1:       begin out_ready = (or_ph % 3 == 0); or_ph++; end
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    logic         p_ack, p_rdy, p_ov, p_or, p_busy, p_load;
    logic [31:0]  p_od;
    logic [127:0] p_a, p_b;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            ab_q.delete();
            {p_ack, p_rdy, p_ov, p_or, p_busy, p_load} = '0;
        end else begin
            if (busy) chk("in_ready_while_busy", in_ready, 1'b0);
            if (mult_result_ack) chk("no_emit_during_ack", out_valid, 1'b0);
            if (p_ack && p_rdy) chk("ack_held", mult_result_ack, 1'b1);
            if (p_ack && !p_rdy) begin
                chk("ack_fall", mult_result_ack, 1'b0);
                chk("emit_after_ack", out_valid, 1'b1);
            end
            if (p_ov && !p_or) begin
                chk("out_valid_held", out_valid, 1'b1);
                chk("out_data_stable", out_data, p_od);
            end
            if (p_busy) chk("operands_stable", {mult_A, mult_B}, {p_a, p_b});
            if (p_load) chk("load_one_cycle", mult_load, 1'b0);
            if (mult_load) begin
                loads++;
                if (ab_q.size() == 0) fail_now("unexpected_load");
                else chk("pack_AB", {mult_A, mult_B}, ab_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.tol) chk_ulp("golden_word", out_data, e.w);
                    else chk("result_word", out_data, e.w);
                end
            end
            p_ack  = mult_result_ack;
            p_rdy  = mult_result_ready;
            p_ov   = out_valid;
            p_or   = out_ready;
            p_od   = out_data;
            p_busy = busy;
            p_load = mult_load;
            p_a    = mult_A;
            p_b    = mult_B;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 4000) abort("in_accept_timeout");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input words_t w, input int n, input int gap_max, input bit keep_valid);
        for (int k = 0; k < n; k++) begin
            int g;
            in_data  = w[k];
            in_valid = 1'b1;
            wait_accept();
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (g > 0) begin
                in_valid = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic issue_set(input words_t w, input bit exp_res, input bit golden_mode,
                             input logic [127:0] golden, input int gap_max, input bit keep_valid);
        logic [127:0] r;
        ab_q.push_back({w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]});
        if (exp_res) begin
            r = golden_mode ? golden : ref_mul(w);
            for (int j = 0; j < 4; j++) exp_q.push_back('{w: r[127-32*j -: 32], tol: golden_mode});
        end
        send_words(w, 8, gap_max, keep_valid);
    endtask

    task automatic rand_set(output words_t w);
        for (int k = 0; k < 8; k++) w[k] = rand_word();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
            n++;
            if (n > 3000) begin
                fail_now(name);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_load"}, mult_load, 1'b0);
        chk({tag, "_A"}, mult_A, 128'd0);
        chk({tag, "_B"}, mult_B, 128'd0);
        chk({tag, "_ack"}, mult_result_ack, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, timeout_err, 1'b0);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        words_t w, w2;
        logic [127:0] golden;
        int l0, n;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        late_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Golden product, no back-pressure
        w = '{32'h40BAE148, 32'h41028F5C, 32'hC040A3D7, 32'hC1200000,
              32'h41A73333, 32'hC14CCCCD, 32'h4115999A, 32'h40000000};
        golden = {32'h43465A1D, 32'hC269BA5E, 32'hC31C68B4, 32'h41943958};
        l0 = loads;
        issue_set(w, 1'b1, 1'b1, golden, 0, 1'b0);
        wait_idle("golden_idle");
        chk("single_load", loads - l0, 1);

        // Long result_ready hold after ack
        hold_cfg = 5;
        rand_set(w);
        issue_set(w, 1'b1, 1'b0, '0, 0, 1'b0);
        wait_idle("handshake_idle");
        hold_cfg = 0;

        // Output back-pressure 1,0,0 pattern
        or_mode = 1;
        for (int s = 0; s < 2; s++) begin
            rand_set(w);
            issue_set(w, 1'b1, 1'b0, '0, 0, 1'b0);
        end
        wait_idle("backpressure_idle");
        or_mode = 0;

        // Timeout, late ready ignored, then recovery
        never_mode = 1'b1;
        rand_set(w);
        issue_set(w, 1'b0, 1'b0, '0, 0, 1'b0);
        n = 0;
        while (!timeout_err && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_cycle", n, TO);
        chk("timeout_busy", busy, 1'b0);
        never_mode = 1'b0;
        late_rdy   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        late_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("late_ready_busy", busy, 1'b0);
        chk("err_sticky", timeout_err, 1'b1);
        rand_set(w);
        issue_set(w, 1'b1, 1'b0, '0, 0, 1'b0);
        chk("err_cleared", timeout_err, 1'b0);
        wait_idle("recovery_idle");

        // Input gaps, reset mid-collect, reset during EMIT
        rand_set(w);
        issue_set(w, 1'b1, 1'b0, '0, 3, 1'b0);
        wait_idle("gaps_idle");
        rand_set(w);
        send_words(w, 5, 2, 1'b0);
        pulse_reset("rst_collect");
        rand_set(w);
        issue_set(w, 1'b1, 1'b0, '0, 2, 1'b0);
        wait_idle("after_reset_idle");
        rand_set(w);
        issue_set(w, 1'b1, 1'b0, '0, 0, 1'b0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("emit_wait");
        pulse_reset("rst_emit");
        rand_set(w);
        issue_set(w, 1'b1, 1'b0, '0, 0, 1'b0);
        wait_idle("after_emit_reset_idle");

        // Back-to-back with in_valid held
        rand_set(w);
        rand_set(w2);
        issue_set(w, 1'b1, 1'b0, '0, 0, 1'b1);
        issue_set(w2, 1'b1, 1'b0, '0, 0, 1'b0);
        wait_idle("b2b_idle");

        // Randomized mix
        or_mode = 2;
        for (int s = 0; s < 8; s++) begin
            delay_cfg = int'($urandom_range(0, 8));
            hold_cfg  = int'($urandom_range(0, 4));
            rand_set(w);
            issue_set(w, 1'b1, 1'b0, '0, int'($urandom_range(0, 2)), 1'b0);
            wait_idle("random_idle");
        end
        or_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
